// File: rtl/siso_pkg.sv
// Shared constants and state encoding for the block reverse reader.
//   DATA_W  - soft-value sample width
//   ADDR_W  - block RAM address width
//   MAX_LEN - longest legal block (6144 info + 4 tail)
package siso_pkg;

    localparam int unsigned DATA_W  = 16;
    localparam int unsigned ADDR_W  = 13;
    localparam int unsigned MAX_LEN = 6148;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } rev_state_t;

endpackage

// File: rtl/block_reverse_reader_if.sv
// Stream bundle for the block reverse reader.
//   s_valid/s_data/s_ready        - forward-order write stream into the buffer
//   m_valid/m_data/m_last/m_ready - reverse-order read stream out of the buffer
// slave modport: the buffer itself; master modport: the surrounding logic.
interface block_reverse_reader_if;
    import siso_pkg::*;

    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic              s_ready;
    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic              m_last;
    logic              m_ready;

    modport slave (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_data, m_last
    );

    modport master (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_data, m_last
    );

endinterface

// File: rtl/ram.sv
// Single-port RAM with registered read (1-cycle read latency).
//   clk  - clock
//   we   - write enable for addr
//   addr - shared read/write address
//   din  - write data
//   dout - data of the address presented on the previous cycle
module ram #(
    parameter int unsigned AW = 13,
    parameter int unsigned DW = 16
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout
);

    logic [DW-1:0] mem [2**AW];

    // Read-before-write; contents are never cleared.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= din;
        end
        dout <= mem[addr];
    end

endmodule

// File: rtl/block_reverse_reader.sv
// Buffers one block of soft values in forward order, then replays it last
// element first for the backward (beta) recursion of the SISO decoder.
//   clk, rst - clock, synchronous active-high reset
//   start    - begin a block (IDLE only), blk_len sampled with it
//   blk_len  - block length N, legal 1..MAX_LEN
//   bus      - write stream in (s_*), reverse read stream out (m_*)
//   busy     - block in progress (WRITE or READ)
//   done     - one-cycle pulse after the final read handshake
//   len_err  - one-cycle pulse on start with an illegal blk_len
module block_reverse_reader
    import siso_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [ADDR_W-1:0]       blk_len,
    block_reverse_reader_if.slave   bus,
    output logic                    busy,
    output logic                    done,
    output logic                    len_err
);

    rev_state_t        state;
    logic [ADDR_W-1:0] len_q;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_q;
    logic              issued;
    logic              s_ready_q;
    logic              m_valid_q;
    logic              m_last_q;

    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_dout;
    logic              final_hs;
    logic              issue;
    logic [ADDR_W-1:0] issue_addr;
    logic              len_ok;

    assign bus.s_ready = s_ready_q;
    assign bus.m_valid = m_valid_q;
    assign bus.m_last  = m_last_q;
    assign bus.m_data  = ram_dout;

    assign len_ok = (blk_len != '0) && (blk_len <= ADDR_W'(MAX_LEN));

    // Address mux: advance when the output slot is free or being consumed,
    // otherwise re-present rd_q so dout holds steady under backpressure.
    always_comb begin
        ram_we     = 1'b0;
        ram_addr   = wr_addr;
        final_hs   = 1'b0;
        issue      = 1'b0;
        issue_addr = issued ? (rd_q - ADDR_W'(1)) : (len_q - ADDR_W'(1));
        unique case (state)
            WRITE: begin
                ram_we   = s_ready_q & bus.s_valid;
                ram_addr = wr_addr;
            end
            READ: begin
                final_hs = m_valid_q & bus.m_ready & (rd_q == '0);
                issue    = !issued || ((!m_valid_q || bus.m_ready) && !final_hs);
                ram_addr = issue ? issue_addr : rd_q;
            end
            default: begin
                ram_addr = wr_addr;
            end
        endcase
    end

    // Control FSM with registered stream and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            len_q     <= '0;
            wr_addr   <= '0;
            rd_q      <= '0;
            issued    <= 1'b0;
            s_ready_q <= 1'b0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            len_err   <= 1'b0;
        end else begin
            done    <= 1'b0;
            len_err <= 1'b0;
            unique case (state)
                IDLE: begin
                    // The done cycle is already IDLE; a new start waits one more cycle.
                    if (start && !done) begin
                        if (len_ok) begin
                            len_q     <= blk_len;
                            wr_addr   <= '0;
                            s_ready_q <= 1'b1;
                            busy      <= 1'b1;
                            state     <= WRITE;
                        end else begin
                            len_err <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    if (s_ready_q && bus.s_valid) begin
                        if (wr_addr == len_q - ADDR_W'(1)) begin
                            s_ready_q <= 1'b0;
                            issued    <= 1'b0;
                            state     <= READ;
                        end else begin
                            wr_addr <= wr_addr + ADDR_W'(1);
                        end
                    end
                end
                READ: begin
                    if (final_hs) begin
                        m_valid_q <= 1'b0;
                        m_last_q  <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= IDLE;
                    end else if (issue) begin
                        rd_q      <= issue_addr;
                        m_valid_q <= 1'b1;
                        m_last_q  <= (issue_addr == '0);
                        issued    <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    ram #(
        .AW (ADDR_W),
        .DW (DATA_W)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .addr (ram_addr),
        .din  (bus.s_data),
        .dout (ram_dout)
    );

endmodule

// File: tb/tb_block_reverse_reader.sv
// Directed bench for block_reverse_reader: forward writes, reverse readback,
// backpressure, illegal lengths, start-while-busy and mid-block reset.
module tb_block_reverse_reader;
    import siso_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] blk_len;
    logic              busy;
    logic              done;
    logic              len_err;

    block_reverse_reader_if bus();

    block_reverse_reader dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .blk_len (blk_len),
        .bus     (bus),
        .busy    (busy),
        .done    (done),
        .len_err (len_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] wdata [$];
    logic [DATA_W-1:0] rdata [$];
    logic              rlast [$];
    bit                pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_block(input int n);
        start   = 1'b1;
        blk_len = ADDR_W'(n);
        tick();
        start   = 1'b0;
    endtask

    // Push wdata through the write port; returns after the last handshake edge.
    task automatic write_block(input bit gaps, output bit tmo);
        int idx;
        int cyc;
        logic sr;
        idx = 0;
        cyc = 0;
        while (idx < wdata.size() && cyc < 40000) begin
            bus.s_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            bus.s_data  = wdata[idx];
            sr = bus.s_ready;
            tick();
            if (bus.s_valid && sr) idx++;
            cyc++;
        end
        bus.s_valid = 1'b0;
        tmo = (idx != wdata.size());
    endtask

    // Drain n beats with m_ready held high; returns after the final handshake edge.
    task automatic collect(input int n, output int cycles, output bit tmo);
        int k;
        rdata.delete();
        rlast.delete();
        k = 0;
        cycles = 0;
        while (k < n && cycles < 20000) begin
            bus.m_ready = 1'b1;
            if (bus.m_valid) begin
                rdata.push_back(bus.m_data);
                rlast.push_back(bus.m_last);
                k++;
            end
            tick();
            cycles++;
        end
        tmo = (k != n);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++; if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL reset_s_ready: got %b want 0", bus.s_ready); end
        checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %b want 0", bus.m_valid); end
        checks++; if (bus.m_last  !== 1'b0) begin errors++; $display("FAIL reset_m_last: got %b want 0", bus.m_last); end
        checks++; if (busy    !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done    !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (len_err !== 1'b0) begin errors++; $display("FAIL reset_len_err: got %b want 0", len_err); end
    endtask

    task automatic test_basic();
        bit tmo;
        int cyc;
        wdata.delete();
        for (int i = 1; i <= 8; i++) wdata.push_back(DATA_W'(i));
        begin_block(8);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b want 1", busy); end
        checks++; if (bus.s_ready !== 1'b1) begin errors++; $display("FAIL basic_s_ready: got %b want 1", bus.s_ready); end
        write_block(1'b0, tmo);
        checks++; if (tmo) begin errors++; $display("FAIL basic_write_timeout: got timeout want 8 handshakes"); end
        // First READ cycle: address issued, nothing valid yet.
        checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_early: got %b want 0", bus.m_valid); end
        checks++; if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL basic_s_ready_drop: got %b want 0", bus.s_ready); end
        tick();
        checks++; if (bus.m_valid !== 1'b1) begin errors++; $display("FAIL basic_valid_latency: got %b want 1", bus.m_valid); end
        collect(8, cyc, tmo);
        checks++; if (tmo) begin errors++; $display("FAIL basic_read_timeout: got %0d beats want 8", rdata.size()); end
        checks++; if (cyc !== 8) begin errors++; $display("FAIL basic_no_bubbles: got %0d cycles want 8", cyc); end
        for (int k = 0; k < rdata.size(); k++) begin
            checks++; if (rdata[k] !== DATA_W'(8 - k)) begin errors++; $display("FAIL basic_data[%0d]: got %h want %h", k, rdata[k], DATA_W'(8 - k)); end
            checks++; if (rlast[k] !== (k == 7)) begin errors++; $display("FAIL basic_last[%0d]: got %b want %b", k, rlast[k], (k == 7)); end
        end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL basic_done: got %b want 1", done); end
        checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_drop: got %b want 0", bus.m_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_drop: got %b want 0", busy); end
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got %b want 0", done); end
    endtask

    task automatic test_backpressure();
        bit tmo;
        int k;
        int cyc;
        bit stalled;
        logic [DATA_W-1:0] sd;
        logic sl;
        wdata.delete();
        for (int i = 0; i < 5; i++) wdata.push_back(DATA_W'(16'h0A + i));
        begin_block(5);
        write_block(1'b0, tmo);
        checks++; if (tmo) begin errors++; $display("FAIL bp_write_timeout: got timeout want 5 handshakes"); end
        k = 0;
        cyc = 0;
        stalled = 1'b0;
        sd = '0;
        sl = 1'b0;
        while (k < 5 && cyc < 200) begin
            if (stalled) begin
                checks++;
                if (bus.m_valid !== 1'b1 || bus.m_data !== sd || bus.m_last !== sl) begin
                    errors++;
                    $display("FAIL bp_hold: got v=%b d=%h l=%b want v=1 d=%h l=%b", bus.m_valid, bus.m_data, bus.m_last, sd, sl);
                end
            end
            bus.m_ready = pat[cyc % 6];
            stalled = bus.m_valid && !bus.m_ready;
            sd = bus.m_data;
            sl = bus.m_last;
            if (bus.m_valid && bus.m_ready) begin
                checks++; if (bus.m_data !== DATA_W'(16'h0E - k)) begin errors++; $display("FAIL bp_data[%0d]: got %h want %h", k, bus.m_data, DATA_W'(16'h0E - k)); end
                checks++; if (bus.m_last !== (k == 4)) begin errors++; $display("FAIL bp_last[%0d]: got %b want %b", k, bus.m_last, (k == 4)); end
                k++;
            end
            tick();
            cyc++;
        end
        checks++; if (k !== 5) begin errors++; $display("FAIL bp_beats: got %0d want 5", k); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL bp_done: got %b want 1", done); end
        bus.m_ready = 1'b1;
        tick();
        checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL bp_no_extra: got %b want 0", bus.m_valid); end
    endtask

    task automatic test_gaps_and_limits();
        bit tmo;
        int cyc;
        int nlast;
        wdata.delete();
        for (int i = 0; i < MAX_LEN; i++) wdata.push_back(DATA_W'(i));
        begin_block(MAX_LEN);
        write_block(1'b1, tmo);
        checks++; if (tmo) begin errors++; $display("FAIL max_write_timeout: got timeout want %0d handshakes", MAX_LEN); end
        collect(MAX_LEN, cyc, tmo);
        checks++; if (rdata.size() !== MAX_LEN) begin errors++; $display("FAIL max_beats: got %0d want %0d", rdata.size(), MAX_LEN); end
        nlast = 0;
        for (int k = 0; k < rdata.size(); k++) begin
            checks++; if (rdata[k] !== DATA_W'(MAX_LEN - 1 - k)) begin errors++; $display("FAIL max_data[%0d]: got %h want %h", k, rdata[k], DATA_W'(MAX_LEN - 1 - k)); end
            if (rlast[k]) nlast++;
        end
        checks++; if (nlast !== 1) begin errors++; $display("FAIL max_last_count: got %0d want 1", nlast); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL max_done: got %b want 1", done); end
        tick();

        wdata.delete();
        wdata.push_back(16'hBEEF);
        begin_block(1);
        write_block(1'b0, tmo);
        checks++; if (tmo) begin errors++; $display("FAIL one_write_timeout: got timeout want 1 handshake"); end
        collect(1, cyc, tmo);
        checks++; if (rdata.size() !== 1) begin errors++; $display("FAIL one_beats: got %0d want 1", rdata.size()); end
        if (rdata.size() == 1) begin
            checks++; if (rdata[0] !== 16'hBEEF) begin errors++; $display("FAIL one_data: got %h want beef", rdata[0]); end
            checks++; if (rlast[0] !== 1'b1) begin errors++; $display("FAIL one_last: got %b want 1", rlast[0]); end
        end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL one_done: got %b want 1", done); end
        tick();
    endtask

    task automatic test_illegal_len();
        int bad [2] = '{0, MAX_LEN + 1};
        for (int t = 0; t < 2; t++) begin
            begin_block(bad[t]);
            checks++; if (len_err !== 1'b1) begin errors++; $display("FAIL illegal_len_err(%0d): got %b want 1", bad[t], len_err); end
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL illegal_busy(%0d): got %b want 0", bad[t], busy); end
            checks++; if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL illegal_s_ready(%0d): got %b want 0", bad[t], bus.s_ready); end
            tick();
            checks++; if (len_err !== 1'b0) begin errors++; $display("FAIL illegal_pulse(%0d): got %b want 0", bad[t], len_err); end
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL illegal_idle(%0d): got %b want 0", bad[t], busy); end
        end
    endtask

    task automatic test_start_while_busy();
        bit tmo;
        int cyc;
        wdata.delete();
        for (int i = 0; i < 4; i++) wdata.push_back(DATA_W'(16'h41 + i));
        begin_block(4);
        // Hold a competing start (N = 2) through the whole write and read.
        start   = 1'b1;
        blk_len = ADDR_W'(2);
        write_block(1'b0, tmo);
        checks++; if (tmo) begin errors++; $display("FAIL busy_write_timeout: got timeout want 4 handshakes"); end
        collect(4, cyc, tmo);
        start = 1'b0;
        checks++; if (rdata.size() !== 4) begin errors++; $display("FAIL busy_beats: got %0d want 4", rdata.size()); end
        for (int k = 0; k < rdata.size(); k++) begin
            checks++; if (rdata[k] !== DATA_W'(16'h44 - k)) begin errors++; $display("FAIL busy_data[%0d]: got %h want %h", k, rdata[k], DATA_W'(16'h44 - k)); end
        end
        checks++; if (len_err !== 1'b0) begin errors++; $display("FAIL busy_no_err: got %b want 0", len_err); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL busy_done: got %b want 1", done); end
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_stays_idle: got %b want 0", busy); end
    endtask

    task automatic test_reset_mid();
        bit tmo;
        int cyc;
        int w;
        wdata.delete();
        for (int i = 0; i < 10; i++) wdata.push_back(DATA_W'(16'h100 + i));
        begin_block(10);
        write_block(1'b0, tmo);
        bus.m_ready = 1'b1;
        w = 0;
        while (!bus.m_valid && w < 10) begin
            tick();
            w++;
        end
        tick();
        checks++; if (bus.m_data !== 16'h0108) begin errors++; $display("FAIL rst_second_beat: got %h want 0108", bus.m_data); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL rst_m_valid: got %b want 0", bus.m_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
        checks++; if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL rst_s_ready: got %b want 0", bus.s_ready); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", done); end

        wdata.delete();
        wdata.push_back(16'h11);
        wdata.push_back(16'h22);
        wdata.push_back(16'h33);
        begin_block(3);
        write_block(1'b0, tmo);
        collect(3, cyc, tmo);
        checks++; if (rdata.size() !== 3) begin errors++; $display("FAIL rst_after_beats: got %0d want 3", rdata.size()); end
        for (int k = 0; k < rdata.size(); k++) begin
            checks++; if (rdata[k] !== DATA_W'(16'h33 - 16'h11 * k)) begin errors++; $display("FAIL rst_after_data[%0d]: got %h want %h", k, rdata[k], DATA_W'(16'h33 - 16'h11 * k)); end
        end
        checks++; if (rlast.size() == 3 && rlast[2] !== 1'b1) begin errors++; $display("FAIL rst_after_last: got %b want 1", rlast[2]); end
        tick();
    endtask

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        blk_len     = '0;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.m_ready = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_gaps_and_limits();
        test_illegal_len();
        test_start_while_busy();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
